// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: state encoding, request
// classes, the per-cycle request arbiter and the default tick divide ratio.
package timer_pkg;

    localparam int TICK_DIV_DEFAULT = 100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        REQ_NONE  = 3'd0,
        REQ_LOAD  = 3'd1,
        REQ_START = 3'd2,
        REQ_HALT  = 3'd3,
        REQ_CLEAR = 3'd4
    } req_e;

    // Only the highest-ranked request present in a cycle is acted on.
    function automatic req_e arbitrate(input logic clear_req, input logic halt,
                                       input logic start, input logic load_req);
        req_e win;
        if (clear_req) begin
            win = REQ_CLEAR;
        end else if (halt) begin
            win = REQ_HALT;
        end else if (start) begin
            win = REQ_START;
        end else if (load_req) begin
            win = REQ_LOAD;
        end else begin
            win = REQ_NONE;
        end
        return win;
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Request and strobe bundle between the timer controller (slave) and the
// environment that issues requests and watches the counter chain (master).
interface timer_ctrl_if;
    import timer_pkg::*;

    logic   start;
    logic   stop;
    logic   door_closed;
    logic   load_req;
    logic   clear_req;
    logic   zero_in;
    logic   loadn;
    logic   clrn;
    logic   en;
    logic   run;
    logic   done;
    state_e state;

    modport master (
        output start, stop, door_closed, load_req, clear_req, zero_in,
        input  loadn, clrn, en, run, done, state
    );

    modport slave (
        input  start, stop, door_closed, load_req, clear_req, zero_in,
        output loadn, clrn, en, run, done, state
    );

endinterface

// File: rtl/tick_prescaler.sv
// Modulo-DIV counter with enable, hold and synchronous clear; tc is high
// while the count sits on its last value.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic clr,
    input  logic sclr,
    input  logic cnt_en,
    output logic tc
);

    localparam int              CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_r;

    // Count register: clear has priority, otherwise wrap at LAST or hold.
    always_ff @(posedge clk) begin
        if (clr || sclr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (cnt_en) begin
            if (count_r == LAST) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: sequences load/clear/enable strobes to a downstream
// counter chain through IDLE, SET, RUN, PAUSE and DONE.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input logic         clk,
    input logic         clr,
    timer_ctrl_if.slave bus
);

    state_e state_r;
    state_e next_s;
    req_e   req_s;
    logic   load_prev_r, clear_prev_r;
    logic   load_rise_s, clear_rise_s, halt_s;
    logic   presc_clr_s, presc_en_s, tc_s;
    logic   loadn_s, clrn_s, en_s, run_s, done_s;
    logic   loadn_r, clrn_r, en_r, run_r, done_r;

    // A held request strobes once; only its rising edge produces a pulse.
    assign load_rise_s  = bus.load_req & ~load_prev_r;
    assign clear_rise_s = bus.clear_req & ~clear_prev_r;
    assign halt_s       = bus.stop | ~bus.door_closed;
    assign req_s        = arbitrate(bus.clear_req, halt_s, bus.start, bus.load_req);

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .clr    (clr),
        .sclr   (presc_clr_s),
        .cnt_en (presc_en_s),
        .tc     (tc_s)
    );

    // State register and request edge-detect history.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r      <= ST_IDLE;
            load_prev_r  <= 1'b0;
            clear_prev_r <= 1'b0;
        end else begin
            state_r      <= next_s;
            load_prev_r  <= bus.load_req;
            clear_prev_r <= bus.clear_req;
        end
    end

    // Next-state selection from the winning request of this cycle.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s == REQ_LOAD && load_rise_s) begin
                    next_s = ST_SET;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_SET: begin
                if (req_s == REQ_CLEAR) begin
                    next_s = ST_IDLE;
                end else if (req_s == REQ_START && !bus.zero_in) begin
                    next_s = ST_RUN;
                end else begin
                    next_s = ST_SET;
                end
            end
            ST_RUN: begin
                if (req_s == REQ_CLEAR) begin
                    next_s = ST_IDLE;
                end else if (req_s == REQ_HALT) begin
                    next_s = ST_PAUSE;
                end else if (bus.zero_in) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (req_s == REQ_CLEAR) begin
                    next_s = ST_IDLE;
                end else if (req_s == REQ_START) begin
                    next_s = ST_RUN;
                end else begin
                    next_s = ST_PAUSE;
                end
            end
            ST_DONE: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Output decode; values are registered below so strobes lag inputs by one cycle.
    always_comb begin
        loadn_s     = 1'b1;
        clrn_s      = 1'b1;
        en_s        = 1'b0;
        presc_clr_s = 1'b0;
        presc_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s == REQ_CLEAR) begin
                    clrn_s = ~clear_rise_s;
                end else if (req_s == REQ_LOAD) begin
                    loadn_s = ~load_rise_s;
                end else begin
                    loadn_s = 1'b1;
                end
            end
            ST_SET: begin
                if (req_s == REQ_CLEAR) begin
                    clrn_s = ~clear_rise_s;
                end else if (next_s == ST_RUN) begin
                    presc_clr_s = 1'b1;
                end else if (req_s == REQ_LOAD) begin
                    loadn_s = ~load_rise_s;
                end else begin
                    loadn_s = 1'b1;
                end
            end
            ST_RUN: begin
                // Staying in RUN implies zero_in is low, so tc alone qualifies en.
                if (req_s == REQ_CLEAR) begin
                    clrn_s = ~clear_rise_s;
                end else if (next_s == ST_RUN) begin
                    presc_en_s = 1'b1;
                    en_s       = tc_s;
                end else begin
                    presc_en_s = 1'b0;
                end
            end
            ST_PAUSE: begin
                if (req_s == REQ_CLEAR) begin
                    clrn_s = ~clear_rise_s;
                end else begin
                    clrn_s = 1'b1;
                end
            end
            ST_DONE: begin
                en_s = 1'b0;
            end
            default: begin
                en_s = 1'b0;
            end
        endcase
        run_s  = (next_s == ST_RUN);
        done_s = (next_s == ST_DONE);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            loadn_r <= 1'b1;
            clrn_r  <= 1'b1;
            en_r    <= 1'b0;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            loadn_r <= loadn_s;
            clrn_r  <= clrn_s;
            en_r    <= en_s;
            run_r   <= run_s;
            done_r  <= done_s;
        end
    end

    assign bus.loadn = loadn_r;
    assign bus.clrn  = clrn_r;
    assign bus.en    = en_r;
    assign bus.run   = run_r;
    assign bus.done  = done_r;
    assign bus.state = state_r;

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 100, clk cycles per count-enable tick (≥2).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 clr  input  1  synchronous, active-high reset.
REQ-004 start  input  1  level, request run/resume.
REQ-005 stop  input  1  level, request pause.
REQ-006 door_closed  input  1  high = safe to run.
REQ-007 load_req  input  1  level, request preset load into the counter chain.
REQ-008 clear_req  input  1  level, request clear of the counter chain.
REQ-009 zero_in  input  1  high when every digit of the downstream counter chain reads zero.
REQ-010 loadn  output  1  active-low load strobe to the counter chain.
REQ-011 clrn  output  1  active-low clear strobe to the counter chain.
REQ-012 en  output  1  count-enable strobe to the counter chain.
REQ-013 run  output  1  high while in RUN (load/heater on).
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 state  output  3  current state encoding.

Function
REQ-016 States: IDLE, SET, RUN, PAUSE, DONE; all outputs registered, one-cycle latency from input to output.
REQ-017 Request priority per cycle: clear_req > (stop or !door_closed) > start > load_req.
REQ-018 IDLE: load_req -> loadn=0 for exactly one cycle, next state SET; clear_req -> clrn=0 for one cycle, stay IDLE.
REQ-019 SET: start & door_closed & !zero_in -> RUN, prescaler=0; start with zero_in=1 -> stay SET; load_req -> repeat one-cycle loadn pulse, stay SET; clear_req -> clrn pulse, IDLE.
REQ-020 RUN: run=1; prescaler counts 0..TICK_DIV-1, wraps to 0; en=1 for one cycle when prescaler==TICK_DIV-1 and zero_in=0.
REQ-021 RUN: zero_in=1 -> DONE, run=0 next cycle, no en issued in that cycle.
REQ-022 RUN: stop or !door_closed -> PAUSE, prescaler value held, en=0, run=0.
REQ-023 PAUSE: start & door_closed & !stop -> RUN, prescaler resumes from held value; clear_req -> clrn pulse, IDLE; load_req ignored.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 loadn and clrn never low in the same cycle; en never high while loadn or clrn is low.
REQ-026 Inputs held high generate only one loadn/clrn pulse per state entry (edge-qualified internally).
REQ-027 load_req in RUN ignored; clear_req in RUN -> clrn pulse, IDLE, run=0.

Reset
REQ-028 clr=1 at a rising edge: state=IDLE, prescaler=0, loadn=1, clrn=1, en=0, run=0, done=0, edge-detect registers=0.
REQ-029 clr mid-RUN aborts the run in that cycle; no done pulse is generated.

Structure
REQ-030 Shared package timer_pkg holds state encoding constants and the TICK_DIV default.
REQ-031 One sub-module, tick_prescaler (counter with enable, hold, sync clear, terminal-count output), instantiated once.

Verification (TICK_DIV=4)
REQ-032 clr for 2 cycles -> state=IDLE, loadn=1, clrn=1, en=run=done=0.
REQ-033 load_req 3 cycles in IDLE -> exactly one loadn=0 cycle, state=SET.
REQ-034 SET, zero_in=0, start -> RUN; en pulses every 4th cycle; raise zero_in after 3 en pulses -> DONE, done one cycle, IDLE, exactly 3 en pulses total.
REQ-035 RUN, door_closed=0 after prescaler=2 -> PAUSE, no en; door_closed=1 + start -> RUN, next en after 2 cycles.
REQ-036 clear_req and start same cycle in SET -> clrn pulse, IDLE, run stays 0.
REQ-037 SET with zero_in=1, start -> remains SET, run=0, en never asserted.
